// File: rtl/ad7383_pkg.sv
// Shared types and constants for the AD7383 conversion sequencer.
package ad7383_pkg;

   localparam int ADC_DATA_W = 16;
   localparam int ADC_BITS   = 16;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      SHIFT,
      DONE,
      QUIET
   } seq_state_t;

endpackage

// File: rtl/ad7383_sclk_gen.sv
// SCLK divider for the AD7383 read-out: idles high, each period is CLK_DIV cycles low then CLK_DIV high.
module ad7383_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic ACLK,
   input  logic ARESETN,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic period_done
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             sclk_q;

   // Disabled state presets the counter so the first enabled edge drives SCLK low at once.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cnt    <= CNT_LAST;
         sclk_q <= 1'b1;
      end else if (!en) begin
         cnt    <= CNT_LAST;
         sclk_q <= 1'b1;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         sclk_q <= ~sclk_q;
      end else begin
         cnt    <= cnt + 1'b1;
      end
   end

   assign sclk        = sclk_q;
   assign rise        = !sclk_q && (cnt == CNT_LAST);
   assign period_done =  sclk_q && (cnt == CNT_LAST);

endmodule

// File: rtl/ad7383_conv_sequencer.sv
// AD7383 conversion sequencer and dual-channel serial read-out.
// Optional build macro AD7383_TEST_PATTERN_EN replaces captured data with a frame-counter pattern.
module ad7383_conv_sequencer
   import ad7383_pkg::*;
#(
   parameter int CLK_DIV       = 2,
   parameter int CONV_CYCLES   = 24,
   parameter int QUIET_CYCLES  = 4,
   parameter int SAMPLE_PERIOD = 1000
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  enable_i,
   input  logic                  trigger_i,
   input  logic                  clear_i,
   output logic                  adc_cs_n_o,
   output logic                  adc_sclk_o,
   input  logic                  adc_sdoa_i,
   input  logic                  adc_sdob_i,
   output logic [ADC_DATA_W-1:0] dataA_o,
   output logic [ADC_DATA_W-1:0] dataB_o,
   output logic                  adc_valid_o,
   output logic                  busy_o,
   output logic                  trig_drop_o
);

   localparam int TMR_MAX = (CONV_CYCLES > QUIET_CYCLES) ? CONV_CYCLES : QUIET_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int PER_W   = $clog2(SAMPLE_PERIOD);
   localparam logic [TMR_W-1:0] CONV_LAST  = TMR_W'(CONV_CYCLES - 1);
   localparam logic [TMR_W-1:0] QUIET_LAST = TMR_W'(QUIET_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("ad7383_conv_sequencer: CLK_DIV must be >= 1");
   end
   if (CONV_CYCLES < 1 || QUIET_CYCLES < 1) begin : g_bad_timing
      $error("ad7383_conv_sequencer: CONV_CYCLES and QUIET_CYCLES must be >= 1");
   end
   if (SAMPLE_PERIOD < CONV_CYCLES + 32*CLK_DIV + 1 + QUIET_CYCLES) begin : g_bad_period
      $error("ad7383_conv_sequencer: SAMPLE_PERIOD shorter than one complete frame");
   end

   seq_state_t       state, state_nxt;
   logic [TMR_W-1:0] tmr;
   logic [4:0]       bit_cnt;
   logic [PER_W-1:0] period_cnt;
   logic             enable_q;
   logic             en_rise;
   logic             start;
   logic             sclk_en;
   logic             sclk_rise;
   logic             sclk_period_done;

   assign en_rise = enable_i && !enable_q;
   assign start   = (enable_i && (period_cnt == PER_LAST || en_rise)) || (!enable_i && trigger_i);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)                                      state_nxt = CONVERT;
         CONVERT: if (tmr == CONV_LAST)                           state_nxt = SHIFT;
         SHIFT:   if (sclk_period_done && bit_cnt == 5'(ADC_BITS)) state_nxt = DONE;
         DONE:                                                     state_nxt = QUIET;
         QUIET:   if (tmr == QUIET_LAST)                          state_nxt = IDLE;
         default:                                                  state_nxt = IDLE;
      endcase
   end

   // SCLK enable looks one state ahead so the first low phase lines up with SHIFT entry.
   always_comb begin
      adc_cs_n_o = !(state == CONVERT || state == SHIFT);
      busy_o     = (state != IDLE);
      sclk_en    = (state_nxt == SHIFT);
   end

   ad7383_sclk_gen #(
      .CLK_DIV     (CLK_DIV)
   ) u_sclk_gen (
      .ACLK        (ACLK),
      .ARESETN     (ARESETN),
      .en          (sclk_en),
      .sclk        (adc_sclk_o),
      .rise        (sclk_rise),
      .period_done (sclk_period_done)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)                tmr <= '0;
      else if (state_nxt != state) tmr <= '0;
      else if (state == CONVERT || state == QUIET) tmr <= tmr + 1'b1;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)              bit_cnt <= '0;
      else if (state != SHIFT)   bit_cnt <= '0;
      else if (sclk_rise)        bit_cnt <= bit_cnt + 5'd1;
   end

   // A rising enable arms an immediate start even if it arrives mid-frame.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         period_cnt <= '0;
         enable_q   <= 1'b0;
      end else begin
         enable_q <= enable_i;
         if (state == IDLE && start)    period_cnt <= '0;
         else if (en_rise)              period_cnt <= PER_LAST;
         else if (period_cnt != PER_LAST) period_cnt <= period_cnt + 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)                  trig_drop_o <= 1'b0;
      else if (trigger_i && busy_o)  trig_drop_o <= 1'b1;
      else if (clear_i)              trig_drop_o <= 1'b0;
   end

`ifdef AD7383_TEST_PATTERN_EN
   logic [ADC_DATA_W-1:0] frame_cnt;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         frame_cnt   <= '0;
         dataA_o     <= '0;
         dataB_o     <= '0;
         adc_valid_o <= 1'b0;
      end else begin
         adc_valid_o <= (state == DONE);
         if (state == DONE) begin
            dataA_o   <= frame_cnt;
            dataB_o   <= ~frame_cnt;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end
`else
   logic [ADC_DATA_W-1:0] shift_a, shift_b;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         shift_a <= '0;
         shift_b <= '0;
      end else if (state == SHIFT && sclk_rise) begin
         shift_a <= {shift_a[ADC_DATA_W-2:0], adc_sdoa_i};
         shift_b <= {shift_b[ADC_DATA_W-2:0], adc_sdob_i};
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         dataA_o     <= '0;
         dataB_o     <= '0;
         adc_valid_o <= 1'b0;
      end else begin
         adc_valid_o <= (state == DONE);
         if (state == DONE) begin
            dataA_o <= shift_a;
            dataB_o <= shift_b;
         end
      end
   end
`endif

endmodule
